seven_seg_scan_ctrl: RTL
========================

Name: seven_seg_scan_ctrl

Overview:
Parametrised N-digit multiplexed seven-segment display controller. It is the successor to the fixed 4-digit clock-divider, scanner and decoder chain. It integrates:
- the scan prescaler
- the digit scanner
- the hex decoder
- a PWM brightness control
- leading-zero blanking
- per-digit decimal points
- a double-buffered value register that updates only at frame boundaries, so there is no tearing.

It sits between the arithmetic/value logic and the board an/seg pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8).
DIVIDE_BY, 17, scan slot length is 2**DIVIDE_BY clk cycles; must be >= BRIGHT_W.
BRIGHT_W, 3, width of the brightness input.

Ports:
clk  input  1  system clock, 100 MHz on the board.
reset  input  1  synchronous, active-low reset.
value  input  4*NUM_DIGITS  hex nibbles; nibble i drives digit i, digit 0 is rightmost.
load  input  1  1-cycle strobe; captures value and dp_in into the shadow register.
dp_in  input  NUM_DIGITS  decimal point enables, active-high, captured with load.
blank_lz  input  1  leading-zero blanking enable; live, not buffered.
brightness  input  BRIGHT_W  display duty; live, not buffered.
pending  output  1  high from load until the shadow is applied to the display.
frame_start  output  1  1-cycle pulse when the scan wraps to digit 0.
an  output  NUM_DIGITS  anodes, active-low, one-hot-low or all high.
seg  output  7  {g,f,e,d,c,b,a}, active-low.
dp  output  1  decimal point, active-low.

Behaviour:
- Reset (reset==0 at a clk edge):
  - prescaler=0, digit index=0, shadow=0, active=0, pending=0.
  - an=all 1s, seg=7'h7F, dp=1, frame_start=0.
- Prescaler:
  - DIVIDE_BY-bit counter, increments every clk and wraps naturally.
  - tick is asserted when the counter is all 1s.
- Digit index:
  - Advances on tick; wraps from NUM_DIGITS-1 to 0.
  - On the wrapping tick, frame_start=1 for exactly one cycle (registered, appears the cycle after the tick).
- Buffering:
  - load=1 → shadow<=value/dp_in, pending<=1.
  - Load while pending: last-wins, pending stays 1.
  - On the wrapping tick with pending=1: active<=shadow, and pending<=0 unless load is also 1 on that same cycle.
  - Load on that same cycle: active gets the old shadow; shadow gets the new value; pending stays 1.
- Decoder, hex 0-F, standard active-low:
  - 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, A=7'b0001000, F=7'b0001110.
- Leading-zero blanking:
  - If blank_lz=1, each digit i>0 whose active nibble and all higher nibbles are 0 is blanked (an bit stays 1).
  - Digit 0 is never blanked.
  - A digit with its dp set is not blanked, and neither are digits below it.
- PWM:
  - Let p = top BRIGHT_W bits of the prescaler.
  - The anode is enabled only when p < brightness.
  - brightness = all 1s means always enabled (full duty).
  - brightness = 0 means the display is dark (an all 1s).
- Blanked or PWM-off digit: an bit=1, seg=7'h7F, dp=1.
- Output latency: an/seg/dp are registered, 1 clk after index/prescaler/active change.
  - Exactly one an bit is low at any time, or none.
- Reset mid-frame: everything returns to the reset state on the next edge, and any pending load is discarded.

Decomposition:
- Package seven_seg_pkg holds:
  - the hex-to-segment function (16-entry constant table)
  - SEG_BLANK=7'h7F
  - AN_OFF helper.
- One sub-module, seven_seg_scan_timer, contains:
  - the prescaler
  - the digit index
  - tick/frame_start generation
  - the PWM compare value p
- Top-level seven_seg_scan_ctrl contains:
  - the buffering
  - blanking
  - the decode/output registers.

Test Plan:
All scenarios use NUM_DIGITS=4, DIVIDE_BY=4, BRIGHT_W=3.
1. Reset and scan order: hold reset=0 for 3 cycles, then release → an=4'b1111, seg=7'h7F while in reset. Then load value=16'h1234 with brightness=7 → after the first frame_start, an cycles 1110,1101,1011,0111 every 16 clks with seg=4,3,2,1 codes.
2. Frame-aligned update: load 16'hABCD mid-frame → pending=1 and the display still shows the old value until the next frame_start. At the wrapping tick, digit 0 shows D (7'b0100001) and pending drops to 0.
3. Simultaneous load and apply: load 16'h1111 then load 16'h2222 on the wrapping tick → that frame shows 1111, pending stays 1, and the next frame shows 2222.
4. Leading-zero blanking: value=16'h0050 with blank_lz=1 → digits 3 and 2 are dark and digits 1 and 0 show 5 and 0. With value=16'h0000, only digit 0 shows 0. With dp_in=4'b0100, digit 2 shows 0 with dp=0.
5. Brightness: brightness=2 → within each 16-clk slot, the anode is low for exactly 4 clks (p=0,1). brightness=0 → an=4'b1111 always. brightness=7 → low for all 16.
6. Reset mid-operation: assert reset while pending=1 during digit 2 → the next cycle has index 0, pending=0, an=4'b1111, and the active value is 0.

Source files
------------

// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment controller:
// the hex-to-segment table, the blank pattern and anode drive helpers.
package seven_seg_pkg;

    // Widest display the controller is built for; anode helpers work at this
    // width and the top slices off the digits it actually has.
    localparam int MAX_DIGITS = 8;

    // Segment order is {g,f,e,d,c,b,a}, active-low, so all ones is dark.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // All anodes released (active-low anodes, so all ones is off).
    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

    typedef logic [3:0] nibble_t;

    // Standard active-low hex glyphs, indexed by nibble value 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    function automatic logic [6:0] hex_to_seg(input nibble_t nib);
        return HEX_SEG[nib];
    endfunction

    // Anode pattern with every digit off.
    function automatic logic [MAX_DIGITS-1:0] an_off();
        return AN_OFF;
    endfunction

    // Anode pattern that pulls exactly the selected digit low when on=1,
    // otherwise leaves every anode released.
    function automatic logic [MAX_DIGITS-1:0] an_drive(input logic [2:0] idx,
                                                       input logic       on);
        logic [MAX_DIGITS-1:0] pat;
        pat = an_off();
        if (on) begin
            pat[idx] = 1'b0;
        end
        return pat;
    endfunction

endpackage

// File: rtl/seven_seg_scan_timer.sv
// Scan timing for the seven-segment controller: free-running prescaler,
// digit index, wrap detection, registered frame_start pulse and the PWM
// compare value taken from the top bits of the prescaler.
module seven_seg_scan_timer
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIVIDE_BY  = 17,
    parameter int BRIGHT_W   = 3,
    parameter int IDX_W      = 2
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    output logic                wrap_o,
    output logic [IDX_W-1:0]    idx_o,
    output logic                frame_start_o,
    output logic [BRIGHT_W-1:0] pwm_p_o
);

    logic [DIVIDE_BY-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 fs_q, fs_d;
    logic                 tick;
    logic                 last_digit;

    // Next-state logic: slot tick when the prescaler is all ones, index
    // advances on the tick and wraps after the last digit.
    always_comb begin
        tick       = &presc_q;
        last_digit = (idx_q == IDX_W'(NUM_DIGITS - 1));
        presc_d    = presc_q + DIVIDE_BY'(1);
        idx_d      = idx_q;
        if (tick) begin
            idx_d = last_digit ? '0 : idx_q + IDX_W'(1);
        end
        fs_d = tick && last_digit;
    end

    // Timing state registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            presc_q <= '0;
            idx_q   <= '0;
            fs_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            fs_q    <= fs_d;
        end
    end

    // The wrap is the tick that takes the index from the last digit back to
    // digit 0; the top uses it to swap the display buffer in the same edge.
    assign wrap_o        = tick && last_digit;
    assign idx_o         = idx_q;
    assign frame_start_o = fs_q;
    assign pwm_p_o       = presc_q[DIVIDE_BY-1 -: BRIGHT_W];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// N-digit multiplexed seven-segment controller. Holds a double-buffered
// value/decimal-point register that only swaps on the frame wrap (no
// tearing), applies leading-zero blanking and PWM brightness, and drives
// registered an/seg/dp pins.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIVIDE_BY  = 17,
    parameter int BRIGHT_W   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic                    pending,
    output logic                    frame_start,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    wrap;
    logic [IDX_W-1:0]        idx;
    logic [BRIGHT_W-1:0]     pwm_p;

    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q,  shadow_dp_d;
    logic [4*NUM_DIGITS-1:0] active_val_q, active_val_d;
    logic [NUM_DIGITS-1:0]   active_dp_q,  active_dp_d;
    logic                    pending_q,    pending_d;

    logic [NUM_DIGITS-1:0]   an_q,  an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q,  dp_d;

    logic [NUM_DIGITS-1:0]   blank_vec;
    nibble_t                 cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    pwm_on;
    logic                    show;
    logic [MAX_DIGITS-1:0]   an_pat;

    seven_seg_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIVIDE_BY  (DIVIDE_BY),
        .BRIGHT_W   (BRIGHT_W),
        .IDX_W      (IDX_W)
    ) u_timer (
        .clk_i         (clk),
        .reset_ni      (reset),
        .wrap_o        (wrap),
        .idx_o         (idx),
        .frame_start_o (frame_start),
        .pwm_p_o       (pwm_p)
    );

    // Double buffer: load always writes the shadow; the wrap copies the
    // shadow to the active copy. A load on the wrap edge itself leaves the
    // old shadow going live and keeps the new one pending for next frame.
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        active_val_d = active_val_q;
        active_dp_d  = active_dp_q;
        pending_d    = pending_q;
        if (wrap && pending_q) begin
            active_val_d = shadow_val_q;
            active_dp_d  = shadow_dp_q;
            pending_d    = 1'b0;
        end
        if (load) begin
            shadow_val_d = value;
            shadow_dp_d  = dp_in;
            pending_d    = 1'b1;
        end
    end

    // Leading-zero blanking, scanning from the most significant digit down:
    // once a non-zero nibble or a set decimal point is seen, that digit and
    // all lower ones stay lit. Digit 0 is never blanked.
    always_comb begin
        logic keep;
        keep      = 1'b0;
        blank_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if ((active_val_q[4*i +: 4] != 4'h0) || active_dp_q[i]) begin
                keep = 1'b1;
            end
            blank_vec[i] = blank_lz && (i != 0) && !keep;
        end
    end

    // Select the current digit's data and build the next pin values. Full
    // brightness is a special case because p never exceeds all ones.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = active_val_q[4*i +: 4];
                cur_dp    = active_dp_q[i];
                cur_blank = blank_vec[i];
            end
        end
        pwm_on = (&brightness) || (pwm_p < brightness);
        show   = pwm_on && !cur_blank;
        an_pat = an_drive(3'(idx), show);
        an_d   = an_pat[NUM_DIGITS-1:0];
        seg_d  = show ? hex_to_seg(cur_nib) : SEG_BLANK;
        dp_d   = show ? ~cur_dp : 1'b1;
    end

    // Buffer and output registers; reset discards any pending load and
    // darkens the display.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            active_val_q <= '0;
            active_dp_q  <= '0;
            pending_q    <= 1'b0;
            an_q         <= AN_OFF[NUM_DIGITS-1:0];
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
        end else begin
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            active_val_q <= active_val_d;
            active_dp_q  <= active_dp_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign pending = pending_q;
    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = dp_q;

endmodule
